// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE, its opcode and operands are registered onto the ALU inputs (ISSUE).
// The FSM then allows one settle cycle (WAIT) and captures the ALU result and
// flags into the owning requester's response registers. It holds them (RESP)
// until that requester takes the response.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/_ready       request handshake (ready is combinational)
//   req{0,1}_op/_a/_b           opcode and operands for each requester
//   rsp{0,1}_valid/_ready       response handshake
//   rsp{0,1}_result/_flags      registered result and flags {carry, zero}
//   alu_op/_a/_b                registered operation presented to the ALU
//   alu_result/_flags           ALU outputs, sampled at the end of WAIT
//   busy                        high whenever the FSM is not in IDLE
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN  when defined, req0 always wins simultaneous
//                          requests and the round-robin pointer is not
//                          built. req1 can starve under this option.
//                          Default (undefined) arbitration is round-robin.
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic [1:0]       rsp0_flags,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic [1:0]       rsp1_flags,

    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [1:0]       alu_flags,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   owner;      // requester whose operation is in flight
    logic   grant;      // requester selected in IDLE
    logic   accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // req1 is only granted when req0 has nothing pending.
    always_comb begin
        grant = 1'b0;
        if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end
`else
    logic ptr;          // requester favoured on a tie; reset favours req0

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end
`endif

    always_comb begin
        req0_ready = (state == IDLE) && (grant == 1'b0) && req0_valid;
        req1_ready = (state == IDLE) && (grant == 1'b1) && req1_valid;
        accept     = req0_ready || req1_ready;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr         <= 1'b0;
`endif
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_flags  <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_op <= grant ? req1_op : req0_op;
                        alu_a  <= grant ? req1_a  : req0_a;
                        alu_b  <= grant ? req1_b  : req0_b;
                        owner  <= grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        // The next tie goes to the requester not just served.
                        ptr    <= ~grant;
`endif
                        state  <= ISSUE;
                    end
                end

                ISSUE: begin
                    state <= WAIT;
                end

                WAIT: begin
                    // ALU inputs have been stable for a full cycle here.
                    if (owner == 1'b0) begin
                        rsp0_result <= alu_result;
                        rsp0_flags  <= alu_flags;
                        rsp0_valid  <= 1'b1;
                    end else begin
                        rsp1_result <= alu_result;
                        rsp1_flags  <= alu_flags;
                        rsp1_valid  <= 1'b1;
                    end
                    state <= RESP;
                end

                RESP: begin
                    if (owner == 1'b0) begin
                        if (rsp0_ready) begin
                            rsp0_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end else begin
                        if (rsp1_ready) begin
                            rsp1_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
